// File: rtl/pal_chroma_phase.sv
// PAL chroma phase generator: free-running 16-step subcarrier phase, PAL
// V-axis alternation, colour-burst window timing and a 3-stage modulator
// that turns (hue, amp) into a signed chroma sample.
//
// Ports:
//   clk_col16x   - clock, 16x colour subcarrier
//   reset_n      - asynchronous active-low reset
//   hsync_start  - one-clock line-start pulse
//   vsync_start  - one-clock field-start pulse
//   chroma_en    - active-video chroma enable
//   hue[3:0]     - pixel phase offset, 22.5 degree steps
//   amp[2:0]     - pixel saturation, unsigned
//   phase[3:0]   - subcarrier phase counter
//   v_switch     - PAL V-axis alternation flag
//   burst_on     - colour burst window
//   chroma[10:0] - signed modulated chroma sample, 2 clocks after inputs
module pal_chroma_phase #(
  parameter int BURST_DELAY = 88,
  parameter int BURST_LEN   = 160,
  parameter int BURST_AMP   = 2
) (
  input  logic               clk_col16x,
  input  logic               reset_n,
  input  logic               hsync_start,
  input  logic               vsync_start,
  input  logic               chroma_en,
  input  logic [3:0]         hue,
  input  logic [2:0]         amp,
  output logic [3:0]         phase,
  output logic               v_switch,
  output logic               burst_on,
  output logic signed [10:0] chroma
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_burst;
  logic [3:0]         r_phase;
  logic               r_v;

  logic [3:0]         w_eff;
  logic [2:0]         w_amp;
  logic [3:0]         r_eff;
  logic [2:0]         r_amp1;
  logic signed [7:0]  w_sin;
  logic signed [7:0]  r_sin;
  logic [2:0]         r_amp2;
  logic signed [10:0] w_prod;
  logic signed [10:0] r_chroma;

  // Subcarrier phase: free-running modulo-16 counter.
  always_ff @(posedge clk_col16x or negedge reset_n) begin
    if (!reset_n) r_phase <= 4'd0;
    else          r_phase <= r_phase + 4'd1;
  end

  // V-axis alternation; field start wins over line start.
  always_ff @(posedge clk_col16x or negedge reset_n) begin
    if (!reset_n)         r_v <= 1'b0;
    else if (vsync_start) r_v <= 1'b0;
    else if (hsync_start) r_v <= ~r_v;
  end

  // Burst window FSM. Counter reaching 0 marks expiry; DELAY is loaded with
  // BURST_DELAY so the window opens BURST_DELAY+1 edges after hsync, and
  // BURST is loaded with BURST_LEN-1 so exactly BURST_LEN cycles are high.
  always_ff @(posedge clk_col16x or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_burst <= 1'b0;
    end else if (hsync_start) begin
      r_state <= S_DELAY;
      r_cnt   <= CNT_W'(BURST_DELAY);
      r_burst <= 1'b0;
    end else begin
      case (r_state)
        S_DELAY: begin
          if (r_cnt == '0) begin
            r_state <= S_BURST;
            r_cnt   <= CNT_W'(BURST_LEN - 1);
            r_burst <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_BURST: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_burst <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_burst <= 1'b0;
        end
      endcase
    end
  end

  // Stage-1 effective phase/amplitude; burst uses 135/225 degrees.
  always_comb begin
    w_eff = r_phase;
    w_amp = 3'd0;
    if (r_burst) begin
      w_eff = r_phase + (r_v ? 4'd10 : 4'd6);
      w_amp = 3'(BURST_AMP);
    end else begin
      w_eff = r_v ? (r_phase - hue) : (r_phase + hue);
      w_amp = chroma_en ? amp : 3'd0;
    end
  end

  // 16-entry sine table, 127 full scale.
  always_comb begin
    w_sin = 8'sd0;
    case (r_eff)
      4'd0:  w_sin = 8'sd0;
      4'd1:  w_sin = 8'sd49;
      4'd2:  w_sin = 8'sd90;
      4'd3:  w_sin = 8'sd117;
      4'd4:  w_sin = 8'sd127;
      4'd5:  w_sin = 8'sd117;
      4'd6:  w_sin = 8'sd90;
      4'd7:  w_sin = 8'sd49;
      4'd8:  w_sin = 8'sd0;
      4'd9:  w_sin = -8'sd49;
      4'd10: w_sin = -8'sd90;
      4'd11: w_sin = -8'sd117;
      4'd12: w_sin = -8'sd127;
      4'd13: w_sin = -8'sd117;
      4'd14: w_sin = -8'sd90;
      default: w_sin = -8'sd49;
    endcase
  end

  // |127*7| = 889 fits in 11 signed bits, so the product is exact.
  assign w_prod = 11'(r_sin) * $signed({8'd0, r_amp2});

  // Three register levels: stage-1 sample, table lookup, multiply.
  always_ff @(posedge clk_col16x or negedge reset_n) begin
    if (!reset_n) begin
      r_eff    <= 4'd0;
      r_amp1   <= 3'd0;
      r_sin    <= 8'sd0;
      r_amp2   <= 3'd0;
      r_chroma <= 11'sd0;
    end else begin
      r_eff    <= w_eff;
      r_amp1   <= w_amp;
      r_sin    <= w_sin;
      r_amp2   <= r_amp1;
      r_chroma <= w_prod;
    end
  end

  assign phase    = r_phase;
  assign v_switch = r_v;
  assign burst_on = r_burst;
  assign chroma   = r_chroma;

endmodule

// File: tb/tb_pal_chroma_phase.sv
// Testbench for pal_chroma_phase: directed scenarios plus randomized traffic,
// every cycle compared against a cycle-indexed behavioural model.
module tb_pal_chroma_phase;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               hsync_start = 1'b0;
  logic               vsync_start = 1'b0;
  logic               chroma_en = 1'b0;
  logic [3:0]         hue = 4'd0;
  logic [2:0]         amp = 3'd0;
  logic [3:0]         phase;
  logic               v_switch;
  logic               burst_on;
  logic signed [10:0] chroma;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: values visible after the most recent edge.
  int k;          // edges since reset release
  int last_hs;    // edge index of latest hsync, -1 if none
  int m_phase;
  int m_v;
  int m_b;
  int m_chroma;
  int pipe[$];

  pal_chroma_phase dut (
    .clk_col16x  (clk),
    .reset_n     (reset_n),
    .hsync_start (hsync_start),
    .vsync_start (vsync_start),
    .chroma_en   (chroma_en),
    .hue         (hue),
    .amp         (amp),
    .phase       (phase),
    .v_switch    (v_switch),
    .burst_on    (burst_on),
    .chroma      (chroma)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sine(input int i);
    real r;
    r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 16.0);
    return $rtoi($floor(r + 0.5));
  endfunction

  function automatic int mod16(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  task automatic model_reset();
    k = 0; last_hs = -1; m_phase = 0; m_v = 0; m_b = 0; m_chroma = 0;
    pipe.delete();
    pipe.push_back(0);
    pipe.push_back(0);
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit hs, input bit vs, input bit en,
                            input int h, input int a);
    int eff, am;
    if (m_b != 0) begin
      eff = m_phase + ((m_v != 0) ? 10 : 6);
      am  = 2;
    end else begin
      eff = (m_v != 0) ? m_phase - h : m_phase + h;
      am  = en ? a : 0;
    end
    pipe.push_back(sine(mod16(eff)) * am);
    m_chroma = pipe.pop_front();
    k++;
    m_phase = k % 16;
    if (vs)      m_v = 0;
    else if (hs) m_v = 1 - m_v;
    if (hs) last_hs = k;
    m_b = (last_hs >= 0 && (k - last_hs) >= 89 && (k - last_hs) <= 248) ? 1 : 0;
  endtask

  task automatic step(input bit hs, input bit vs, input bit en,
                      input logic [3:0] h, input logic [2:0] a);
    hsync_start = hs; vsync_start = vs; chroma_en = en; hue = h; amp = a;
    @(posedge clk);
    model_edge(hs, vs, en, int'(h), int'(a));
    #1;
    check("phase",    int'(phase),    m_phase);
    check("v_switch", int'(v_switch), m_v);
    check("burst_on", int'(burst_on), m_b);
    check("chroma",   int'(chroma),   m_chroma);
    hsync_start = 1'b0; vsync_start = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_phase",  int'(phase),    0);
    check("rst_v",      int'(v_switch), 0);
    check("rst_burst",  int'(burst_on), 0);
    check("rst_chroma", int'(chroma),   0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_phase0();
    int n = 0;
    while (m_phase != 0 && n < 20) begin idle(); n++; end
    if (m_phase != 0) check("wait_phase0_timeout", 0, 1);
  endtask

  task automatic wait_burst();
    int n = 0;
    while (m_b == 0 && n < 300) begin idle(); n++; end
    if (m_b == 0) check("wait_burst_timeout", 0, 1);
  endtask

  // Sample (hue, amp) at a phase-0 edge, then compare chroma 2 edges later.
  task automatic pixel_probe(input string tag, input logic [3:0] h,
                             input logic [2:0] a, input int exp);
    wait_phase0();
    step(1'b0, 1'b0, 1'b1, h, a);
    idle();
    idle();
    check(tag, int'(chroma), exp);
  endtask

  initial begin
    int first, cnt;
    model_reset();
    #2;
    do_reset();

    // Free-running phase, no stimulus.
    for (int i = 0; i < 20; i++) idle();

    // Pixel modulation on both V-axis polarities.
    pixel_probe("hue4_amp7_v0", 4'd4, 3'd7, 889);
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0);
    check("v_after_hs", int'(v_switch), 1);
    pixel_probe("hue4_amp7_v1", 4'd4, 3'd7, -889);

    // Burst modulation, v=1 (hsync above) then v=0.
    wait_burst();
    pixel_probe("burst_v1", 4'd0, 3'd0, -180);
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0);
    wait_burst();
    pixel_probe("burst_v0", 4'd0, 3'd0, 180);

    // Burst window position and length after a single hsync.
    step(1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0);
    check("v_toggle_to_1", int'(v_switch), 1);
    first = -1; cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      idle();
      if (burst_on) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("burst_first", first, 89);
    check("burst_len", cnt, 160);

    // Simultaneous hsync/vsync with v=1, then a restart 50 clocks later.
    check("v_before_both", int'(v_switch), 1);
    step(1'b1, 1'b1, 1'b0, 4'd0, 3'd0);
    check("vsync_wins", int'(v_switch), 0);
    for (int i = 0; i < 49; i++) idle();
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0);
    first = -1;
    for (int i = 1; i <= 300; i++) begin
      idle();
      if (burst_on && first < 0) first = i;
    end
    check("restart_first", first, 89);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 999) == 0,
           1'($urandom), 4'($urandom), 3'($urandom));
    end

    // Reset mid-burst: outputs drop at once, no burst until a new hsync.
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0, 1'b1, 4'($urandom), 3'd7);
    check("in_burst_before_rst", int'(burst_on), 1);
    #2;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      idle();
      if (burst_on) cnt++;
    end
    check("no_burst_after_rst", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pal_chroma_phase.md
PAL_CHROMA_PHASE -- requirements
Module: pal_chroma_phase

Interface
REQ-001 SHALL have parameter BURST_DELAY, default 88, meaning clocks from hsync_start to burst start (5.5 subcarrier cycles).
REQ-002 SHALL have parameter BURST_LEN, default 160, meaning burst length in clocks (10 subcarrier cycles).
REQ-003 SHALL have parameter BURST_AMP, default 2, meaning 3-bit amplitude used during burst.
REQ-004 SHALL have port clk_col16x, input, 1 bit: the single clock, 16x the PAL colour subcarrier; all logic rises on it.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port hsync_start, input, 1 bit: one-clock pulse marking line start.
REQ-007 SHALL have port vsync_start, input, 1 bit: one-clock pulse marking field start.
REQ-008 SHALL have port chroma_en, input, 1 bit: active-video chroma enable.
REQ-009 SHALL have port hue, input, 4 bits: pixel phase offset in 22.5-degree steps.
REQ-010 SHALL have port amp, input, 3 bits: pixel saturation, unsigned.
REQ-011 SHALL have port phase, output, 4 bits: subcarrier phase counter.
REQ-012 SHALL have port v_switch, output, 1 bit: PAL V-axis alternation flag.
REQ-013 SHALL have port burst_on, output, 1 bit: colour burst window.
REQ-014 SHALL have port chroma, output, 11 bits, signed: modulated chroma sample.

Function
REQ-015 SHALL increment phase by 1 every clock, wrapping 15 -> 0.
REQ-016 SHALL toggle v_switch on each hsync_start; vsync_start SHALL clear v_switch to 0, winning over a simultaneous hsync_start.
REQ-017 SHALL implement FSM IDLE/DELAY/BURST with a down-counter: hsync_start in any state -> DELAY (load BURST_DELAY); DELAY at count expiry -> BURST (load BURST_LEN); BURST at expiry -> IDLE.
REQ-018 SHALL assert burst_on (registered) exactly in the clock cycles after edges n+BURST_DELAY+1 through n+BURST_DELAY+BURST_LEN, where hsync_start is sampled at edge n.
REQ-019 SHALL restart the sequence on an hsync_start arriving during DELAY or BURST, deasserting burst_on at the next edge.
REQ-020 SHALL compute stage-1 effective phase (mod 16) from the current phase and v_switch register values: burst_on=1 -> phase+6 (v_switch=0, 135 deg) or phase+10 (v_switch=1, 225 deg), amplitude BURST_AMP; otherwise phase+hue (v_switch=0) or phase-hue (v_switch=1), amplitude amp.
REQ-021 SHALL force stage-1 amplitude to 0 when burst_on=0 and chroma_en=0.
REQ-022 SHALL use a 16-entry signed 8-bit sine table, sin(2*pi*k/16)*127 rounded: 0,49,90,117,127,117,90,49,0,-49,-90,-117,-127,-117,-90,-49.
REQ-023 SHALL output chroma = table[eff] * amplitude, full precision (range -889..+889), no truncation.
REQ-024 SHALL have a fixed latency of 2 clocks: inputs sampled at edge n appear on chroma after edge n+2, with no stalls.

Reset
REQ-025 SHALL, while reset_n=0, immediately force phase=0, v_switch=0, FSM=IDLE, counter=0, burst_on=0, chroma=0, and all pipeline registers=0.
REQ-026 SHALL, after reset_n deasserts, show phase=1 after the first rising edge; reset asserted mid-burst SHALL drop burst_on asynchronously with no resumption after release.

Verification
REQ-027 SHALL verify reset release with no stimulus -> phase counts 1,2..15,0; chroma=0, burst_on=0 throughout.
REQ-028 SHALL verify hsync_start at edge n with default parameters -> burst_on high for exactly 160 clocks starting after edge n+89; v_switch toggles to 1 after edge n.
REQ-029 SHALL verify v_switch=0, chroma_en=1, hue=4, amp=7, phase=0 at sampling -> chroma=+889 two clocks later; same with v_switch=1 -> chroma=-889.
REQ-030 SHALL verify burst with phase=0 sampled: v_switch=0 -> chroma=+180; v_switch=1 -> chroma=-180.
REQ-031 SHALL verify simultaneous hsync_start and vsync_start with v_switch=1 -> v_switch=0, FSM enters DELAY; a second hsync_start 50 clocks later restarts the delay count.
REQ-032 SHALL verify reset_n pulsed low mid-burst -> burst_on and chroma at 0 immediately; no burst after release until the next hsync_start.
